sprite_plot_scheduler: RTL and testbench

- Per-frame sequencer and single-port arbiter that shares the one VGA plot port among up to NUM_SPRITES sprite draw engines (birds, hunter).
- On each frame tick it erases every sprite drawn last frame, then pulses a move strobe so engines update positions, then draws every currently active sprite.
- It serves one engine at a time in fixed index order and muxes that engine's pixel stream onto vga_x/vga_y/vga_colour/vga_plot.
- Sits between frame_counter, the sprite engines and vga_adapter.

---
 rtl/sprite_plot_scheduler_if.sv | 41 ++++
 rtl/sprite_plot_scheduler.sv | 155 +++++++++++++++
 tb/tb_sprite_plot_scheduler.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_plot_scheduler_if.sv
// Plot-port bus between the frame scheduler, the sprite engines and the VGA adapter.
// master is the scheduler side; slave is the engines/adapter side.
interface sprite_plot_scheduler_if #(
    parameter int NUM_SPRITES = 7,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COLOUR_W    = 3
);
    logic                            frame_tick;
    logic [NUM_SPRITES-1:0]          active_mask;
    logic [NUM_SPRITES*COLOUR_W-1:0] sprite_colour;
    logic [NUM_SPRITES*X_W-1:0]      pix_x;
    logic [NUM_SPRITES*Y_W-1:0]      pix_y;
    logic [NUM_SPRITES-1:0]          pix_valid;
    logic [NUM_SPRITES-1:0]          eng_done;
    logic [NUM_SPRITES-1:0]          eng_start;
    logic                            erase;
    logic                            move_en;
    logic [X_W-1:0]                  vga_x;
    logic [Y_W-1:0]                  vga_y;
    logic [COLOUR_W-1:0]             vga_colour;
    logic                            vga_plot;
    logic                            busy;
    logic                            frame_overrun;

    modport master (
        input  frame_tick, active_mask, sprite_colour,
        input  pix_x, pix_y, pix_valid, eng_done,
        output eng_start, erase, move_en,
        output vga_x, vga_y, vga_colour, vga_plot,
        output busy, frame_overrun
    );

    modport slave (
        output frame_tick, active_mask, sprite_colour,
        output pix_x, pix_y, pix_valid, eng_done,
        input  eng_start, erase, move_en,
        input  vga_x, vga_y, vga_colour, vga_plot,
        input  busy, frame_overrun
    );
endinterface

// File: rtl/sprite_plot_scheduler.sv
// Per-frame erase/move/draw sequencer sharing one VGA plot port
// among the sprite engines, served one at a time in index order.
module sprite_plot_scheduler #(
    parameter int                  NUM_SPRITES = 7,
    parameter int                  X_W         = 8,
    parameter int                  Y_W         = 7,
    parameter int                  COLOUR_W    = 3,
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = '0
) (
    input logic                     clock,
    input logic                     resetn,
    sprite_plot_scheduler_if.master bus
);
    localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int N     = NUM_SPRITES;

    typedef enum logic [2:0] {
        IDLE, E_START, E_ARM, E_WAIT,
        MOVE, D_START, D_ARM, D_WAIT
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    state_t              state;
    logic [SEL_W-1:0]    sel;
    logic [N-1:0]        drawn_mask;
    logic [N-1:0]        cur_mask;
    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q;

    // lowest set bit of m at or above index lo
    function automatic pick_t first_from(input logic [N-1:0] m,
                                         input int lo);
        first_from = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i] && i >= lo) begin
                first_from.found = 1'b1;
                first_from.idx   = SEL_W'(i);
            end
        end
    endfunction

    pick_t drawn_first, drawn_next, cur_first, cur_next;

    assign drawn_first = first_from(drawn_mask, 0);
    assign drawn_next  = first_from(drawn_mask, int'(sel) + 1);
    assign cur_first   = first_from(cur_mask, 0);
    assign cur_next    = first_from(cur_mask, int'(sel) + 1);

    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [COLOUR_W-1:0] sel_colour;
    logic                sel_valid;
    logic                sel_done;
    logic                in_erase;
    logic                streaming;

    assign sel_x      = bus.pix_x[int'(sel)*X_W +: X_W];
    assign sel_y      = bus.pix_y[int'(sel)*Y_W +: Y_W];
    assign sel_colour = bus.sprite_colour[int'(sel)*COLOUR_W +: COLOUR_W];
    assign sel_valid  = bus.pix_valid[sel];
    assign sel_done   = bus.eng_done[sel];

    assign in_erase  = (state == E_START) || (state == E_ARM) ||
                       (state == E_WAIT);
    assign streaming = (state == E_ARM) || (state == E_WAIT) ||
                       (state == D_ARM) || (state == D_WAIT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            sel        <= '0;
            drawn_mask <= '0;
            cur_mask   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            if (streaming) begin
                plot_q   <= sel_valid;
                x_q      <= sel_x;
                y_q      <= sel_y;
                colour_q <= in_erase ? BG_COLOUR : sel_colour;
            end

            unique case (state)
                IDLE: begin
                    if (bus.frame_tick) begin
                        cur_mask <= bus.active_mask;
                        if (drawn_first.found) begin
                            sel   <= drawn_first.idx;
                            state <= E_START;
                        end else begin
                            state <= MOVE;
                        end
                    end
                end
                E_START: state <= E_ARM;
                // engine may still show last job's done here
                E_ARM:   state <= E_WAIT;
                E_WAIT: begin
                    if (sel_done) begin
                        if (drawn_next.found) begin
                            sel   <= drawn_next.idx;
                            state <= E_START;
                        end else begin
                            state <= MOVE;
                        end
                    end
                end
                MOVE: begin
                    if (cur_first.found) begin
                        sel   <= cur_first.idx;
                        state <= D_START;
                    end else begin
                        drawn_mask <= cur_mask;
                        state      <= IDLE;
                    end
                end
                D_START: state <= D_ARM;
                D_ARM:   state <= D_WAIT;
                D_WAIT: begin
                    if (sel_done) begin
                        if (cur_next.found) begin
                            sel   <= cur_next.idx;
                            state <= D_START;
                        end else begin
                            drawn_mask <= cur_mask;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.eng_start = ((state == E_START) || (state == D_START)) ?
                           (N'(1) << sel) : '0;
    assign bus.erase         = in_erase;
    assign bus.move_en       = (state == MOVE);
    assign bus.busy          = (state != IDLE);
    assign bus.frame_overrun = bus.frame_tick && (state != IDLE);
    assign bus.vga_x         = x_q;
    assign bus.vga_y         = y_q;
    assign bus.vga_colour    = colour_q;
    assign bus.vga_plot      = plot_q;
endmodule

// File: tb/tb_sprite_plot_scheduler.sv
// Directed bench for sprite_plot_scheduler with simple
// 13-pixel sprite engine models driving the plot bus.
module tb_sprite_plot_scheduler;
    localparam int N = 7;

    logic clock;
    logic resetn;

    sprite_plot_scheduler_if bus ();

    sprite_plot_scheduler dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // engine models: start -> 13 pixels x=40 downward -> done
    logic [N-1:0] done_r;
    logic [N-1:0] valid_r;
    logic [N-1:0] armed;
    logic [N-1:0] hold;
    logic [7:0]   xr   [N];
    int           rem  [N];
    logic         late;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) begin
                done_r[i]  <= 1'b1;
                valid_r[i] <= 1'b0;
                armed[i]   <= 1'b0;
                xr[i]      <= 8'd0;
                rem[i]     <= 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.eng_start[i] && late) begin
                    armed[i] <= 1'b1;
                end else if (bus.eng_start[i] || armed[i]) begin
                    armed[i]   <= 1'b0;
                    done_r[i]  <= 1'b0;
                    valid_r[i] <= 1'b1;
                    xr[i]      <= 8'd40;
                    rem[i]     <= 13;
                end else if (rem[i] > 1) begin
                    rem[i] <= rem[i] - 1;
                    xr[i]  <= xr[i] - 8'd1;
                end else if (rem[i] == 1) begin
                    rem[i]     <= 0;
                    valid_r[i] <= 1'b0;
                    done_r[i]  <= 1'b1;
                end
            end
        end
    end

    assign bus.pix_valid = valid_r;
    assign bus.eng_done  = done_r & ~hold;
    assign bus.pix_y     = '0;

    always_comb begin
        bus.pix_x = '0;
        for (int i = 0; i < N; i++) bus.pix_x[i*8 +: 8] = xr[i];
    end

    // mid-cycle observers
    logic [N-1:0] start_log [$];
    int move_cnt = 0;
    int plot_bg  = 0;
    int plot_c0  = 0;
    int plot_c2  = 0;
    int plot_oth = 0;

    always @(negedge clock) begin
        if (bus.eng_start != '0) start_log.push_back(bus.eng_start);
        if (bus.move_en) move_cnt++;
        if (bus.vga_plot) begin
            case (bus.vga_colour)
                3'b000:  plot_bg++;
                3'b101:  plot_c0++;
                3'b011:  plot_c2++;
                default: plot_oth++;
            endcase
        end
    end

    int b_start, b_move, b_bg, b_c0, b_c2, b_oth;

    task automatic snap();
        b_start = start_log.size();
        b_move  = move_cnt;
        b_bg    = plot_bg;
        b_c0    = plot_c0;
        b_c2    = plot_c2;
        b_oth   = plot_oth;
    endtask

    function automatic logic [N-1:0] log_at(input int k);
        if (b_start + k < start_log.size()) return start_log[b_start + k];
        return '1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy && n < 2000) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 2000), 32'd1);
    endtask

    task automatic wait_move(input string tag);
        int n;
        n = 0;
        while (!bus.move_en && n < 2000) begin
            step();
            n++;
        end
        chk(tag, 32'(n < 2000), 32'd1);
    endtask

    task automatic chk_frame(input string tag, input int starts,
                             input int bg, input int c0, input int c2);
        chk({tag, "_starts"}, 32'(start_log.size() - b_start), 32'(starts));
        chk({tag, "_moves"},  32'(move_cnt - b_move), 32'd1);
        chk({tag, "_bg"},     32'(plot_bg - b_bg), 32'(bg));
        chk({tag, "_c0"},     32'(plot_c0 - b_c0), 32'(c0));
        chk({tag, "_c2"},     32'(plot_c2 - b_c2), 32'(c2));
        chk({tag, "_other"},  32'(plot_oth - b_oth), 32'd0);
    endtask

    initial begin
        resetn            = 1'b0;
        late              = 1'b0;
        hold              = '0;
        bus.frame_tick    = 1'b0;
        bus.active_mask   = '0;
        bus.sprite_colour = {3'b110, 3'b110, 3'b110, 3'b110,
                             3'b011, 3'b110, 3'b101};
        steps(3);
        chk("rst_busy",     32'(bus.busy), 32'd0);
        chk("rst_start",    32'(bus.eng_start), 32'd0);
        chk("rst_ctl",      32'({bus.erase, bus.move_en,
                                 bus.vga_plot, bus.frame_overrun}), 32'd0);
        chk("rst_vga",      32'({bus.vga_x, bus.vga_y, bus.vga_colour}),
                            32'd0);

        // frame 1: nothing drawn yet, straight to move
        resetn = 1'b1;
        bus.active_mask = 7'b0000101;
        step();
        snap();
        tick();
        chk("f1_move",      32'(bus.move_en), 32'd1);
        chk("f1_erase",     32'(bus.erase), 32'd0);
        chk("f1_busy",      32'(bus.busy), 32'd1);
        step();
        chk("f1_start0",    32'(bus.eng_start), 32'h01);
        wait_idle("f1_idle");
        chk_frame("f1", 2, 0, 13, 13);
        chk("f1_order0",    32'(log_at(0)), 32'h01);
        chk("f1_order1",    32'(log_at(1)), 32'h04);

        // frame 2: erase 0 and 2, then draw 0 and 2
        step();
        snap();
        tick();
        chk("f2_erase",     32'(bus.erase), 32'd1);
        chk("f2_estart",    32'(bus.eng_start), 32'h01);
        wait_move("f2_wmove");
        chk("f2_erase_bg",  32'(plot_bg - b_bg), 32'd26);
        chk("f2_pre_draw",  32'(plot_c0 - b_c0), 32'd0);
        step();
        chk("f2_dstart",    32'(bus.eng_start), 32'h01);
        step();
        chk("f2_arm_plot",  32'(bus.vga_plot), 32'd0);
        chk("f2_arm_pix",   32'(bus.pix_x[7:0]), 32'd40);
        step();
        chk("f2_lag_plot",  32'(bus.vga_plot), 32'd1);
        chk("f2_lag_x",     32'(bus.vga_x), 32'd40);
        chk("f2_lag_col",   32'(bus.vga_colour), 32'd5);
        chk("f2_lag_pix",   32'(bus.pix_x[7:0]), 32'd39);
        wait_idle("f2_idle");
        chk_frame("f2", 4, 26, 13, 13);
        chk("f2_order2",    32'(log_at(2)), 32'h01);
        chk("f2_order3",    32'(log_at(3)), 32'h04);

        // frame 3: sprite 0 deactivated, still erased once
        bus.active_mask = 7'b0000100;
        step();
        snap();
        tick();
        wait_idle("f3_idle");
        chk_frame("f3", 3, 26, 0, 13);
        chk("f3_order0",    32'(log_at(0)), 32'h01);
        chk("f3_order2",    32'(log_at(2)), 32'h04);

        // frame 4: only sprite 2 remains drawn
        step();
        snap();
        tick();
        wait_idle("f4_idle");
        chk_frame("f4", 2, 13, 0, 13);

        // hung engine: dropped tick while busy
        hold = 7'b0000100;
        step();
        snap();
        tick();
        steps(98);
        chk("hang_busy1",   32'(bus.busy), 32'd1);
        bus.frame_tick = 1'b1;
        #1;
        chk("hang_ovr_on",  32'(bus.frame_overrun), 32'd1);
        step();
        bus.frame_tick = 1'b0;
        #1;
        chk("hang_ovr_off", 32'(bus.frame_overrun), 32'd0);
        steps(400);
        chk("hang_busy2",   32'(bus.busy), 32'd1);
        chk("hang_starts",  32'(start_log.size() - b_start), 32'd1);
        chk("hang_nomove",  32'(move_cnt - b_move), 32'd0);
        hold = '0;
        wait_idle("hang_idle");
        chk_frame("hang", 2, 13, 0, 13);

        // done still high through the arm cycle
        late = 1'b1;
        step();
        snap();
        tick();
        wait_idle("arm_idle");
        chk_frame("arm", 2, 13, 0, 13);
        late = 1'b0;

        // reset during draw wait
        step();
        tick();
        wait_move("rst_wmove");
        steps(3);
        chk("rst_mid_busy0", 32'(bus.busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_ctl",  32'({bus.erase, bus.move_en, bus.vga_plot}),
                            32'd0);
        chk("rst_mid_vga",  32'({bus.vga_x, bus.vga_y, bus.vga_colour}),
                            32'd0);
        chk("rst_mid_st",   32'(bus.eng_start), 32'd0);
        steps(2);
        resetn = 1'b1;
        step();
        snap();
        tick();
        chk("rst_nxt_move", 32'(bus.move_en), 32'd1);
        chk("rst_nxt_era",  32'(bus.erase), 32'd0);
        wait_idle("rst_nxt_idle");
        chk_frame("rst_nxt", 1, 0, 0, 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
